// File: rtl/pe_mac_sat.sv
// pe_mac_sat: output-stationary fixed-point MAC PE with round-half-up conversion and a double-buffered drain-chain result.
// Define PE_SAT_EN to clamp the converted result and raise the sticky ovf_o flag on a saturating capture.
module pe_mac_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] srca_i,
  input  logic [DATA_WIDTH-1:0] srcb_i,
  input  logic                  cap_i,
  input  logic                  drain_i,
  input  logic [DATA_WIDTH-1:0] psum_i,
  output logic                  clr_o,
  output logic                  we_o,
  output logic [DATA_WIDTH-1:0] srca_o,
  output logic [DATA_WIDTH-1:0] srcb_o,
  output logic [DATA_WIDTH-1:0] psum_o,
  output logic                  ovf_o
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH + 1)'(1) <<< (FRAC_BITS - 1);
  logic [DATA_WIDTH-1:0] srca_q, srcb_q, res_q, res_d, conv;
  logic clr_q, we_q;
  logic signed [PW-1:0] prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, prod_x;
  always_comb begin
    prod_d = PW'($signed(srca_i)) * PW'($signed(srcb_i));
    prod_x = ACC_WIDTH'(prod_q);
    acc_d  = clr_q ? (we_q ? prod_x : '0) : (we_q ? acc_q + prod_x : acc_q);
    res_d  = cap_i ? conv : drain_i ? psum_i : res_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      srca_q <= '0;
      srcb_q <= '0;
      clr_q  <= 1'b0;
      we_q   <= 1'b0;
      prod_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
    end else begin
      srca_q <= srca_i;
      srcb_q <= srcb_i;
      clr_q  <= clr_i;
      we_q   <= we_i;
      prod_q <= prod_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
    end
  end
`ifdef PE_SAT_EN
  logic signed [ACC_WIDTH:0] r;
  logic sat, ovf_q, ovf_d;
  // In range exactly when every bit from the result sign upward agrees.
  always_comb begin
    r     = ((ACC_WIDTH + 1)'(acc_q) + HALF) >>> FRAC_BITS;
    sat   = !((&r[ACC_WIDTH:DATA_WIDTH-1]) || !(|r[ACC_WIDTH:DATA_WIDTH-1]));
    conv  = sat ? {r[ACC_WIDTH], {(DATA_WIDTH-1){~r[ACC_WIDTH]}}} : r[DATA_WIDTH-1:0];
    ovf_d = cap_i ? (sat | (ovf_q & ~clr_q)) : ovf_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf_o = ovf_q;
`else
  always_comb conv = DATA_WIDTH'(((ACC_WIDTH + 1)'(acc_q) + HALF) >>> FRAC_BITS);
  assign ovf_o = 1'b0;
`endif
  assign srca_o = srca_q;
  assign srcb_o = srcb_q;
  assign clr_o  = clr_q;
  assign we_o   = we_q;
  assign psum_o = res_q;
endmodule

// File: tb/tb_pe_mac_sat.sv
// tb_pe_mac_sat: directed bench for a 3-deep pe_mac_sat column; expectations are queued at drive time and checked after the next edge.
module tb_pe_mac_sat;
`ifdef PE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    string tag;
    int sel;
    int pe;
    logic [15:0] exp;
  } exp_t;
  logic clk = 1'b0;
  logic rst, drain;
  logic [15:0] head;
  logic clr[3], we[3], cap[3];
  logic [15:0] a[3], b[3];
  logic [15:0] psum[3], sa[3], sb[3];
  logic ovf[3], clro[3], weo[3];
  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  pe_mac_sat u0 (.clk_i(clk), .rst_i(rst), .clr_i(clr[0]), .we_i(we[0]), .srca_i(a[0]), .srcb_i(b[0]),
    .cap_i(cap[0]), .drain_i(drain), .psum_i(head), .clr_o(clro[0]), .we_o(weo[0]),
    .srca_o(sa[0]), .srcb_o(sb[0]), .psum_o(psum[0]), .ovf_o(ovf[0]));
  pe_mac_sat u1 (.clk_i(clk), .rst_i(rst), .clr_i(clr[1]), .we_i(we[1]), .srca_i(a[1]), .srcb_i(b[1]),
    .cap_i(cap[1]), .drain_i(drain), .psum_i(psum[0]), .clr_o(clro[1]), .we_o(weo[1]),
    .srca_o(sa[1]), .srcb_o(sb[1]), .psum_o(psum[1]), .ovf_o(ovf[1]));
  pe_mac_sat u2 (.clk_i(clk), .rst_i(rst), .clr_i(clr[2]), .we_i(we[2]), .srca_i(a[2]), .srcb_i(b[2]),
    .cap_i(cap[2]), .drain_i(drain), .psum_i(psum[1]), .clr_o(clro[2]), .we_o(weo[2]),
    .srca_o(sa[2]), .srcb_o(sb[2]), .psum_o(psum[2]), .ovf_o(ovf[2]));
  function automatic logic [15:0] obs(int sel, int k);
    return sel == 0 ? psum[k] : sel == 1 ? {15'b0, ovf[k]} : sel == 2 ? sa[k] :
           sel == 3 ? sb[k] : sel == 4 ? {15'b0, weo[k]} : {15'b0, clro[k]};
  endfunction
  task automatic expect_v(string tag, int sel, int k, logic [15:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.pe = k;
    x.exp = e;
    sbq.push_back(x);
  endtask
  task automatic tick();
    exp_t x;
    logic [15:0] o;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      o = obs(x.sel, x.pe);
      checks++;
      assert (o === x.exp) else begin
        errors++;
        $error("FAIL %s pe%0d: observed %h expected %h", x.tag, x.pe, o, x.exp);
      end
    end
  endtask
  task automatic mac(int k, logic c, logic w, logic [15:0] av, logic [15:0] bv);
    clr[k] = c;
    we[k] = w;
    a[k] = av;
    b[k] = bv;
    tick();
    clr[k] = 1'b0;
    we[k] = 1'b0;
    a[k] = '0;
    b[k] = '0;
  endtask
  task automatic capture(int k, string tag, logic [15:0] e, logic eo);
    cap[k] = 1'b1;
    expect_v(tag, 0, k, e);
    expect_v({tag, "_ovf"}, 1, k, {15'b0, eo});
    tick();
    cap[k] = 1'b0;
  endtask
  task automatic expect_zero(string tag, int k);
    for (int s = 0; s < 6; s++) expect_v(tag, s, k, 16'h0000);
  endtask
  initial begin
    rst = 1'b1;
    drain = 1'b0;
    head = 16'hAAAA;
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0;
      we[k] = 1'b0;
      cap[k] = 1'b0;
      a[k] = '0;
      b[k] = '0;
    end
    tick();
    for (int k = 0; k < 3; k++) expect_zero("reset", k);
    tick();
    rst = 1'b0;
    expect_v("fwd_a", 2, 0, 16'h0180);
    expect_v("fwd_b", 3, 0, 16'h0200);
    expect_v("fwd_we", 4, 0, 16'h0001);
    expect_v("fwd_clr", 5, 0, 16'h0001);
    mac(0, 1'b1, 1'b1, 16'h0180, 16'h0200);
    expect_v("fwd_a2", 2, 0, 16'h0100);
    expect_v("fwd_clr2", 5, 0, 16'h0000);
    mac(0, 1'b0, 1'b1, 16'h0100, 16'h0100);
    expect_v("fwd_we2", 4, 0, 16'h0000);
    tick();
    capture(0, "basic", 16'h0400, 1'b0);
    mac(0, 1'b1, 1'b1, 16'h0001, 16'h0080);
    tick();
    capture(0, "round_pos", 16'h0001, 1'b0);
    mac(0, 1'b1, 1'b1, 16'hFFFF, 16'h0080);
    tick();
    capture(0, "round_neg", 16'h0000, 1'b0);
    mac(0, 1'b1, 1'b1, 16'h7F00, 16'h7F00);
    repeat (3) mac(0, 1'b0, 1'b1, 16'h7F00, 16'h7F00);
    tick();
    capture(0, "sat", SAT ? 16'h7FFF : 16'h0400, SAT);
    mac(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tick();
    capture(0, "sticky", 16'h0000, SAT);
    mac(0, 1'b1, 1'b1, 16'h0200, 16'h0100);
    mac(0, 1'b1, 1'b1, 16'h0100, 16'h0100);
    capture(0, "ovl_old", 16'h0200, 1'b0);
    capture(0, "ovl_new", 16'h0100, 1'b0);
    mac(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    tick();
    capture(0, "clr_only", 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b1;
      we[k] = 1'b1;
      a[k] = 16'(16'h0011 * (k + 1));
      b[k] = 16'h0100;
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0;
      we[k] = 1'b0;
      a[k] = '0;
      b[k] = '0;
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      cap[k] = 1'b1;
      expect_v("chain_cap", 0, k, 16'(16'h0011 * (k + 1)));
    end
    tick();
    for (int k = 0; k < 3; k++) cap[k] = 1'b0;
    drain = 1'b1;
    expect_v("drain1_tail", 0, 2, 16'h0022);
    expect_v("drain1_head", 0, 0, 16'hAAAA);
    tick();
    expect_v("drain2_tail", 0, 2, 16'h0011);
    tick();
    expect_v("drain3_tail", 0, 2, 16'hAAAA);
    tick();
    cap[2] = 1'b1;
    head = 16'h5555;
    expect_v("cap_wins", 0, 2, 16'h0033);
    expect_v("cap_drain_mid", 0, 1, 16'hAAAA);
    expect_v("cap_drain_head", 0, 0, 16'h5555);
    tick();
    cap[2] = 1'b0;
    drain = 1'b0;
    mac(0, 1'b1, 1'b1, 16'h0500, 16'h0100);
    we[0] = 1'b1;
    clr[0] = 1'b1;
    a[0] = 16'h0700;
    b[0] = 16'h0100;
    rst = 1'b1;
    expect_zero("rst_acc", 0);
    tick();
    rst = 1'b0;
    we[0] = 1'b0;
    clr[0] = 1'b0;
    a[0] = '0;
    b[0] = '0;
    drain = 1'b1;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) expect_v("rst_drain", 0, k, 16'h0000);
    tick();
    rst = 1'b0;
    drain = 1'b0;
    mac(0, 1'b0, 1'b1, 16'h0100, 16'h0100);
    tick();
    capture(0, "post_rst", 16'h0100, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
